// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
  localparam int WS_W = 4;
endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the datapath (master) and the data memory (slave).
interface dmem_responder_if #(
  parameter int n = 32
);
  logic         req;
  logic         we;
  logic [n-1:0] addr;
  logic [n-1:0] wdata;
  logic [n-1:0] rdata;
  logic         ready;
  logic         err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/dmem_responder_wait_counter.sv
// Loadable down-counter that times the wait states before a response.
module wait_counter
  import mem_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [WS_W-1:0] value,
  input  logic            en,
  output logic            last
);
  logic [WS_W-1:0] count;

  // load has priority; counting stops at zero
  always_ff @(posedge clk) begin
    if (reset)                    count <= '0;
    else if (load)                count <= value;
    else if (en && count != '0)   count <= count - 1'b1;
  end

  // a zero load means "respond now", so last fires straight from the load
  assign last = (count == WS_W'(1)) || (load && value == '0);
endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory with fixed wait states and one-cycle ready pulse.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int n           = 32,
  parameter int depth       = 256,
  parameter int wait_states = 2
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus
);
  localparam int AW = $clog2(depth);

  mem_state_t   state_q, state_d;
  logic         cap_we;
  logic [n-1:0] cap_addr, cap_wdata;
  logic         ctr_load, ctr_en, ctr_last, commit;
  logic         eff_we, acc_err;
  logic [n-1:0] eff_addr, eff_wdata;
  logic [AW-1:0] idx;
  logic [n-1:0] mem [depth];

  assign ctr_load = (state_q == IDLE) && bus.req;
  assign ctr_en   = (state_q == WAIT);

  wait_counter u_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (ctr_load),
    .value (WS_W'(wait_states)),
    .en    (ctr_en),
    .last  (ctr_last)
  );

  // with zero wait states the response commits on the capture edge, so the
  // live bus is used there; otherwise only the captured copy is trusted
  assign eff_we    = (state_q == IDLE) ? bus.we    : cap_we;
  assign eff_addr  = (state_q == IDLE) ? bus.addr  : cap_addr;
  assign eff_wdata = (state_q == IDLE) ? bus.wdata : cap_wdata;

  // depth is a power of two, so out-of-range is any set bit above the index
  assign idx     = eff_addr[AW+1:2];
  assign acc_err = (|eff_addr[1:0]) || (|eff_addr[n-1:AW+2]);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state; commit marks the edge that enters RESP
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (bus.req) begin
        if (ctr_last) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (ctr_last) begin
        state_d = RESP;
        commit  = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // capture the request so later bus changes cannot disturb it
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (ctr_load) begin
      cap_we    <= bus.we;
      cap_addr  <= bus.addr;
      cap_wdata <= bus.wdata;
    end
  end

  // registered response; rdata/err hold until the next response
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= commit;
      if (commit) begin
        bus.err   <= acc_err;
        bus.rdata <= (!eff_we && !acc_err) ? mem[idx] : '0;
      end
    end
  end

  // array write; a reset on the commit edge suppresses the store
  always_ff @(posedge clk) begin
    if (!reset && commit && eff_we && !acc_err) mem[idx] <= eff_wdata;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench: two responders (2 wait states/256 words, 0 wait states/16 words)
// driven by directed and random accesses against a transaction-level model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.n(32)) b0 ();
  dmem_responder_if #(.n(32)) b1 ();

  dmem_responder #(.n(32), .depth(256), .wait_states(2)) u0 (.clk(clk), .reset(reset), .bus(b0));
  dmem_responder #(.n(32), .depth(16),  .wait_states(0)) u1 (.clk(clk), .reset(reset), .bus(b1));

  logic        rq [2];
  logic        wv [2];
  logic [31:0] av [2];
  logic [31:0] dv [2];
  logic        rdy [2];
  logic        er [2];
  logic [31:0] rd [2];

  assign b0.req = rq[0]; assign b0.we = wv[0]; assign b0.addr = av[0]; assign b0.wdata = dv[0];
  assign b1.req = rq[1]; assign b1.we = wv[1]; assign b1.addr = av[1]; assign b1.wdata = dv[1];
  assign rdy[0] = b0.ready; assign er[0] = b0.err; assign rd[0] = b0.rdata;
  assign rdy[1] = b1.ready; assign er[1] = b1.err; assign rd[1] = b1.rdata;

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction
  function automatic int dep_of(input int d);
    return (d == 0) ? 256 : 16;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          d;
    int          due;
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
  } txn_t;

  txn_t        pend [$];
  logic [31:0] mm [2][256];
  bit          mv [2][256];
  logic [31:0] hrd [2];
  bit          herr [2];
  bit          hknown [2];

  int cyc = 0;
  int last_rst = -1;

  // edge counter; remembers the edge number of the latest reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) last_rst <= cyc + 1;
  end

  // compare process: one check set per DUT on every falling edge
  initial begin
    int   hit;
    txn_t t;
    bit   e;
    bit   known;
    logic [31:0] exp_rd;
    int   ix;
    forever begin
      @(negedge clk);
      if (last_rst == cyc) begin
        pend.delete();
        for (int d = 0; d < 2; d++) begin
          hrd[d] = '0; herr[d] = 1'b0; hknown[d] = 1'b1;
        end
      end
      for (int d = 0; d < 2; d++) begin
        hit = -1;
        for (int i = 0; i < pend.size(); i++)
          if (pend[i].d == d && pend[i].due == cyc) hit = i;
        chk($sformatf("ready[%0d] cyc%0d", d, cyc), {31'b0, rdy[d]}, {31'b0, hit >= 0});
        if (hit >= 0) begin
          t = pend[hit];
          pend.delete(hit);
          e = (t.a[1:0] != 2'b0) || ((t.a >> 2) >= 32'(dep_of(d)));
          known = 1'b1;
          exp_rd = '0;
          if (!e) begin
            ix = int'(t.a >> 2);
            if (t.we) begin
              mm[d][ix] = t.wd;
              mv[d][ix] = 1'b1;
            end else if (mv[d][ix]) begin
              exp_rd = mm[d][ix];
            end else begin
              known = 1'b0;
            end
          end
          chk($sformatf("err[%0d] a=%h", d, t.a), {31'b0, er[d]}, {31'b0, e});
          if (known) chk($sformatf("rdata[%0d] a=%h", d, t.a), rd[d], exp_rd);
          hrd[d] = exp_rd; herr[d] = e; hknown[d] = known;
        end else if (hknown[d]) begin
          chk($sformatf("hold_rdata[%0d]", d), rd[d], hrd[d]);
          chk($sformatf("hold_err[%0d]", d), {31'b0, er[d]}, {31'b0, herr[d]});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // issue one access and wait (bounded) for its ready; optionally disturb
  // the bus and drop req once the request has been captured
  task automatic access(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input bit mess,
                        output logic [31:0] ord, output logic oerr);
    txn_t t;
    int   acc_edge;
    int   lat;
    @(negedge clk);
    rq[d] = 1'b1; wv[d] = w; av[d] = a; dv[d] = wd;
    acc_edge = cyc + 1;
    t.d = d; t.due = acc_edge + ws_of(d); t.we = w; t.a = a; t.wd = wd;
    pend.push_back(t);
    lat = -1; ord = 'x; oerr = 1'bx;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mess) begin
        av[d] = $urandom(); dv[d] = $urandom(); wv[d] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) rq[d] = 1'b0;
      end
      if (rdy[d]) begin
        lat = cyc - acc_edge + 1;
        ord = rd[d]; oerr = er[d];
        break;
      end
    end
    rq[d] = 1'b0;
    chk($sformatf("latency[%0d] a=%h", d, a), 32'(lat), 32'(ws_of(d) + 1));
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, 7) * 4);
    else if (r == 7) return 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
    else if (r == 8) return 32'((dep_of(d) + $urandom_range(0, 100)) * 4);
    else             return $urandom();
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] o;
    logic        oe;
    int          d;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; wv[i] = 1'b0; av[i] = '0; dv[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready[%0d]", i), {31'b0, rdy[i]}, 32'h0);
      chk($sformatf("reset_rdata[%0d]", i), rd[i], 32'h0);
      chk($sformatf("reset_err[%0d]", i), {31'b0, er[i]}, 32'h0);
    end
    reset = 1'b0;

    // basic store/load, two wait states
    access(0, 1, 32'h10, 32'hDEADBEEF, 0, o, oe);
    chk("st10_err", {31'b0, oe}, 32'h0);
    chk("st10_rdata", o, 32'h0);
    access(0, 0, 32'h10, 32'h0, 0, o, oe);
    chk("ld10_rdata", o, 32'hDEADBEEF);
    chk("ld10_err", {31'b0, oe}, 32'h0);

    // zero wait states, minimum spacing back to back
    access(1, 1, 32'h0, 32'h1, 0, o, oe);
    access(1, 0, 32'h0, 32'h0, 0, o, oe);
    chk("ws0_ld0", o, 32'h1);
    for (int i = 0; i < 6; i++) access(1, (i % 2) == 0, 32'(4 * (i / 2 + 1)), 32'(100 + i), 0, o, oe);
    access(1, 0, 32'h8, 32'h0, 0, o, oe);
    chk("ws0_ld8", o, 32'd102);

    // misaligned store leaves memory alone
    access(0, 1, 32'h13, 32'h55555555, 0, o, oe);
    chk("mis_err", {31'b0, oe}, 32'h1);
    access(0, 0, 32'h10, 32'h0, 0, o, oe);
    chk("mis_ld10", o, 32'hDEADBEEF);

    // out of range: no aliasing onto word 0, load reads zero with err
    access(0, 1, 32'h0, 32'h12345678, 0, o, oe);
    access(0, 1, 32'h400, 32'h87654321, 0, o, oe);
    chk("oor_st_err", {31'b0, oe}, 32'h1);
    access(0, 0, 32'h400, 32'h0, 0, o, oe);
    chk("oor_ld_err", {31'b0, oe}, 32'h1);
    chk("oor_ld_rdata", o, 32'h0);
    access(0, 0, 32'h0, 32'h0, 0, o, oe);
    chk("oor_ld0", o, 32'h12345678);

    // reset one cycle into WAIT aborts the store
    access(0, 1, 32'h20, 32'h11111111, 0, o, oe);
    @(negedge clk);
    rq[0] = 1'b1; wv[0] = 1'b1; av[0] = 32'h20; dv[0] = 32'hCAFEF00D;
    begin
      txn_t t;
      t.d = 0; t.due = cyc + 3; t.we = 1'b1; t.a = 32'h20; t.wd = 32'hCAFEF00D;
      pend.push_back(t);
    end
    @(negedge clk);
    reset = 1'b1; rq[0] = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready", {31'b0, rdy[0]}, 32'h0);
    chk("rst_wait_rdata", rd[0], 32'h0);
    chk("rst_wait_err", {31'b0, er[0]}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    access(0, 0, 32'h20, 32'h0, 0, o, oe);
    chk("rst_wait_ld20", o, 32'h11111111);

    // reset on the very edge that would commit the store
    access(0, 1, 32'h24, 32'hAAAA0001, 0, o, oe);
    @(negedge clk);
    rq[0] = 1'b1; wv[0] = 1'b1; av[0] = 32'h24; dv[0] = 32'hBBBB0002;
    begin
      txn_t t;
      t.d = 0; t.due = cyc + 3; t.we = 1'b1; t.a = 32'h24; t.wd = 32'hBBBB0002;
      pend.push_back(t);
    end
    @(negedge clk);
    rq[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_edge_ready", {31'b0, rdy[0]}, 32'h0);
    reset = 1'b0;
    access(0, 0, 32'h24, 32'h0, 0, o, oe);
    chk("rst_edge_ld24", o, 32'hAAAA0001);

    // bus disturbed during WAIT: captured values win
    access(0, 1, 32'h30, 32'h0BADF00D, 1, o, oe);
    access(0, 0, 32'h30, 32'h0, 1, o, oe);
    chk("mess_ld30", o, 32'h0BADF00D);

    // random traffic on both responders
    for (int i = 0; i < 300; i++) begin
      d = $urandom_range(0, 1);
      access(d, 1'($urandom_range(0, 1)), rand_addr(d), $urandom(),
             1'($urandom_range(0, 3) == 0), o, oe);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
